// File: rtl/i2c_master.sv
// Single-master I2C controller: START, {addr,rw}, 0..MAX_BYTES data bytes, STOP; open-drain SDA.
// Optional: define I2C_MASTER_RETRY_EN to retry a NACKed address up to MAX_RETRY times.
module i2c_master #(
  parameter int unsigned CLK_DIV   = 25,
  parameter int unsigned MAX_BYTES = 10,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      start_i,
  input  logic [6:0]                addr_i,
  input  logic                      rw_i,
  input  logic [3:0]                num_bytes_i,
  input  logic [MAX_BYTES-1:0][7:0] data_wr_i,
  output logic [MAX_BYTES-1:0][7:0] data_rd_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      ack_err_o,
  output logic                      scl_o,
  inout  wire                       sda_io
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StStart  = 4'd1;
  localparam logic [3:0] StAddr   = 4'd2;
  localparam logic [3:0] StAAck   = 4'd3;
  localparam logic [3:0] StWrByte = 4'd4;
  localparam logic [3:0] StWrAck  = 4'd5;
  localparam logic [3:0] StRdByte = 4'd6;
  localparam logic [3:0] StRdAck  = 4'd7;
  localparam logic [3:0] StStop   = 4'd8;

  localparam logic [9:0] QLast  = 10'(CLK_DIV - 1);
  localparam logic [3:0] MaxCnt = 4'(MAX_BYTES);

  logic [3:0]                state_q, state_d;
  logic [9:0]                qcnt_q, qcnt_d;
  logic [1:0]                quarter_q, quarter_d;
  logic [2:0]                bit_q, bit_d;
  logic [3:0]                byte_q, byte_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [7:0]                adr_q, adr_d;
  logic [7:0]                sh_q, sh_d;
  logic [MAX_BYTES-1:0][7:0] wr_q, wr_d;
  logic [MAX_BYTES-1:0][7:0] rd_q, rd_d;
  logic                      samp_q, samp_d;
  logic                      ack_err_q, ack_err_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
`ifdef I2C_MASTER_RETRY_EN
  localparam int unsigned RetryW = (MAX_RETRY < 4) ? 2 : $clog2(MAX_RETRY + 1);
  logic [RetryW-1:0] retry_q, retry_d;
  logic              again_q, again_d;
`endif

  logic sda_in, sda_low, qlast, samp_pt, bit_end;

  assign sda_in  = sda_io;
  assign sda_io  = sda_low ? 1'b0 : 1'bz;
  assign qlast   = (qcnt_q == QLast);
  assign samp_pt = qlast && (quarter_q == 2'd2);
  assign bit_end = qlast && (quarter_q == 2'd3);

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    sh_d      = sh_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    samp_d    = samp_q;
    ack_err_d = ack_err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef I2C_MASTER_RETRY_EN
    retry_d   = retry_q;
    again_d   = again_q;
`endif
    if (state_q == StIdle) begin
      // done_q guard: a start coinciding with the done pulse is dropped
      if (start_i && !done_q) begin
        state_d   = StStart;
        qcnt_d    = '0;
        quarter_d = '0;
        bit_d     = '0;
        byte_d    = '0;
        adr_d     = {addr_i, rw_i};
        cnt_d     = (num_bytes_i > MaxCnt) ? MaxCnt : num_bytes_i;
        wr_d      = data_wr_i;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
`ifdef I2C_MASTER_RETRY_EN
        retry_d   = '0;
        again_d   = 1'b0;
`endif
      end
    end else begin
      qcnt_d = qlast ? '0 : qcnt_q + 10'd1;
      if (qlast) quarter_d = quarter_q + 2'd1;
      if (samp_pt) begin
        samp_d = sda_in;
        if (state_q == StRdByte) sh_d = {sh_q[6:0], sda_in};
      end
      if (bit_end) begin
        unique case (state_q)
          StStart: begin
            state_d = StAddr;
            sh_d    = adr_q;
            bit_d   = '0;
          end
          StAddr, StWrByte: begin
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = (state_q == StAddr) ? StAAck : StWrAck;
          end
          StAAck: begin
            if (samp_q) begin
`ifdef I2C_MASTER_RETRY_EN
              if (retry_q < RetryW'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                again_d = 1'b1;
              end else begin
                ack_err_d = 1'b1;
              end
`else
              ack_err_d = 1'b1;
`endif
              state_d = StStop;
            end else if (cnt_q == 4'd0) begin
              state_d = StStop;
            end else if (adr_q[0]) begin
              state_d = StRdByte;
            end else begin
              state_d = StWrByte;
              sh_d    = wr_q[0];
            end
          end
          StWrAck: begin
            if (samp_q) begin
              ack_err_d = 1'b1;
              state_d   = StStop;
            end else if (byte_q + 4'd1 == cnt_q) begin
              state_d = StStop;
            end else begin
              byte_d  = byte_q + 4'd1;
              sh_d    = wr_q[byte_q + 4'd1];
              state_d = StWrByte;
            end
          end
          StRdByte: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rd_d[byte_q] = sh_q;
              state_d      = StRdAck;
            end
          end
          StRdAck: begin
            if (byte_q + 4'd1 == cnt_q) begin
              state_d = StStop;
            end else begin
              byte_d  = byte_q + 4'd1;
              state_d = StRdByte;
            end
          end
          StStop: begin
`ifdef I2C_MASTER_RETRY_EN
            if (again_q) begin
              again_d = 1'b0;
              state_d = StStart;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
`else
            state_d = StIdle;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Bus pins decode from registered state so SDA changes only at quarter boundaries.
  always_comb begin
    scl_o   = 1'b1;
    sda_low = 1'b0;
    unique case (state_q)
      StIdle: ;
      StStart: sda_low = quarter_q[1];
      StAddr, StWrByte: begin
        scl_o   = quarter_q[1];
        sda_low = ~sh_q[7];
      end
      StRdAck: begin
        scl_o   = quarter_q[1];
        sda_low = (byte_q + 4'd1 != cnt_q);
      end
      StStop: begin
        scl_o   = quarter_q[1];
        sda_low = (quarter_q != 2'd3);
      end
      default: scl_o = quarter_q[1];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      qcnt_q    <= '0;
      quarter_q <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      cnt_q     <= '0;
      adr_q     <= '0;
      sh_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      samp_q    <= 1'b0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef I2C_MASTER_RETRY_EN
      retry_q   <= '0;
      again_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      sh_q      <= sh_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      samp_q    <= samp_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef I2C_MASTER_RETRY_EN
      retry_q   <= retry_d;
      again_q   <= again_d;
`endif
    end
  end

  assign data_rd_o = rd_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ack_err_o = ack_err_q;

endmodule
